// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

  // Controller/ack bytes that never represent a key.
  function automatic logic is_non_key(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
           (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises ps2_clk/ps2_data and debounces the clock; emits a one-cycle
// pulse when the filtered clock falls.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       filt;
  logic       filt_d1;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      filt_d1  <= 1'b1;
      cnt      <= 8'd0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      filt_d1  <= filt;
      // cnt tracks how long the synchronised clock has disagreed with filt
      if (clk_sync[1] == filt) begin
        cnt <= 8'd0;
      end else if (cnt == CNT_LAST) begin
        filt <= clk_sync[1];
        cnt  <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign fall      = filt_d1 & ~filt;
  assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 frame receiver with scancode folding (E0/F0 prefixes, E1 Pause).
// state  | meaning
// IDLE   | waiting for a start bit
// DATA   | shifting in 8 data bits, LSB first
// PARITY | waiting for the odd-parity bit
// STOP   | waiting for the stop bit; validates the frame
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_released,
  output logic       key_strobe
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic         data;
  logic         fall;
  frame_state_t state, state_d;
  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic         par;
  logic [TW-1:0] tmo_cnt;
  logic         valid_d, perr_d, ferr_d;
  logic         ext, rel;
  logic [2:0]   skip_cnt;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_sync(data),
    .fall     (fall)
  );

  always_comb begin
    state_d = state;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      IDLE:   if (fall && !data) state_d = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_d = PARITY;
      PARITY: if (fall) state_d = STOP;
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (data && (^shreg ^ par)) valid_d = 1'b1;
          else if (!data)             ferr_d  = 1'b1;
          else                        perr_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state != IDLE && !fall && tmo_cnt == TMO_LAST) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      shreg         <= 8'd0;
      par           <= 1'b0;
      tmo_cnt       <= '0;
      rx_byte       <= 8'd0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      state         <= state_d;
      rx_valid      <= valid_d;
      rx_parity_err <= perr_d;
      rx_frame_err  <= ferr_d;
      if (valid_d) rx_byte <= shreg;
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE: bit_cnt <= 3'd0;
          DATA: begin
            shreg   <= {data, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par <= data;
          default: ;
        endcase
      end
    end
  end

  // Scancode layer runs one cycle behind the byte pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext          <= 1'b0;
      rel          <= 1'b0;
      skip_cnt     <= 3'd0;
      key_code     <= 8'd0;
      key_ext      <= 1'b0;
      key_released <= 1'b0;
      key_strobe   <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (rx_parity_err || rx_frame_err) begin
        ext      <= 1'b0;
        rel      <= 1'b0;
        skip_cnt <= 3'd0;
      end else if (rx_valid) begin
        if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BREAK) begin
          rel <= 1'b1;
        end else if (rx_byte == PS2_PAUSE) begin
          skip_cnt <= PAUSE_TAIL_LEN;
          ext      <= 1'b0;
          rel      <= 1'b0;
        end else if (is_non_key(rx_byte)) begin
          ext <= 1'b0;
          rel <= 1'b0;
        end else begin
          key_code     <= rx_byte;
          key_ext      <= ext;
          key_released <= rel;
          key_strobe   <= 1'b1;
          ext          <= 1'b0;
          rel          <= 1'b0;
        end
      end
    end
  end

endmodule
